// File: rtl/uart_cmd_parser.sv
// UART host command decoder: assembles 8-byte SYNC/CMD/ADDR/D0-D3/CSUM frames, issues
// register writes/reads and returns ACK/NAK/read-data bytes. Optional inter-byte timeout: UART_CMD_TIMEOUT_EN.
module uart_cmd_parser #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned TIMEOUT_US = 2000,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic        reg_wr,
  output logic        reg_rd,
  input  logic        reg_ack,
  input  logic [31:0] reg_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic [7:0]  err_count
);

  localparam int unsigned TIMEOUT_CYCLES = CLK_FREQ / 1_000_000 * TIMEOUT_US;

  typedef enum logic [2:0] {
    ST_SYNC, ST_CMD, ST_ADDR, ST_DATA, ST_CSUM, ST_WR, ST_RD, ST_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  csum_q, csum_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  reg_addr_q, reg_addr_d;
  logic [31:0] reg_wdata_q, reg_wdata_d;
  logic [39:0] resp_q, resp_d;
  logic [2:0]  resp_len_q, resp_len_d;
  logic [7:0]  err_q, err_d;
  logic [7:0]  err_inc;
  logic        in_frame;
  logic        tmo_fire;

  assign in_frame = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                    (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign err_inc  = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

`ifdef UART_CMD_TIMEOUT_EN
  // Counts idle cycles between bytes of a partially received frame.
  logic [31:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = 32'd0;
    if (in_frame && !rx_valid) tmo_d = tmo_q + 32'd1;
  end

  assign tmo_fire = in_frame && !rx_valid && (tmo_q >= TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (rst) tmo_q <= 32'd0;
    else     tmo_q <= tmo_d;
  end
`else
  assign tmo_fire = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SYNC;
      cmd_q       <= 8'd0;
      addr_q      <= 8'd0;
      data_q      <= 32'd0;
      csum_q      <= 8'd0;
      cnt_q       <= 2'd0;
      reg_addr_q  <= 8'd0;
      reg_wdata_q <= 32'd0;
      resp_q      <= 40'd0;
      resp_len_q  <= 3'd0;
      err_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      csum_q      <= csum_d;
      cnt_q       <= cnt_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      resp_q      <= resp_d;
      resp_len_q  <= resp_len_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    data_d      = data_q;
    csum_d      = csum_q;
    cnt_d       = cnt_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    resp_d      = resp_q;
    resp_len_d  = resp_len_q;
    err_d       = err_q;
    case (state_q)
      ST_SYNC: if (rx_valid && rx_data == SYNC_BYTE) begin
        state_d = ST_CMD;
        csum_d  = 8'd0;
        cnt_d   = 2'd0;
      end
      ST_CMD: if (rx_valid) begin
        cmd_d   = rx_data;
        csum_d  = csum_q ^ rx_data;
        state_d = ST_ADDR;
      end
      ST_ADDR: if (rx_valid) begin
        addr_d  = rx_data;
        csum_d  = csum_q ^ rx_data;
        state_d = ST_DATA;
      end
      // Data arrives LSB first, so shift new bytes in from the top.
      ST_DATA: if (rx_valid) begin
        data_d = {rx_data, data_q[31:8]};
        csum_d = csum_q ^ rx_data;
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = ST_CSUM;
      end
      ST_CSUM: if (rx_valid) begin
        reg_addr_d  = addr_q;
        reg_wdata_d = data_q;
        if (rx_data == csum_q && cmd_q == 8'h01)      state_d = ST_WR;
        else if (rx_data == csum_q && cmd_q == 8'h02) state_d = ST_RD;
        else begin
          err_d      = err_inc;
          resp_d     = 40'h15;
          resp_len_d = 3'd1;
          state_d    = ST_RESP;
        end
      end
      ST_WR: if (reg_ack) begin
        resp_d     = 40'h06;
        resp_len_d = 3'd1;
        state_d    = ST_RESP;
      end
      ST_RD: if (reg_ack) begin
        resp_d     = {reg_rdata, 8'h06};
        resp_len_d = 3'd5;
        state_d    = ST_RESP;
      end
      ST_RESP: if (tx_ready) begin
        resp_d     = {8'd0, resp_q[39:8]};
        resp_len_d = resp_len_q - 3'd1;
        if (resp_len_q == 3'd1) state_d = ST_SYNC;
      end
      default: state_d = ST_SYNC;
    endcase
    if (tmo_fire) begin
      state_d = ST_SYNC;
      err_d   = err_inc;
    end
  end

  always_comb begin
    reg_wr    = (state_q == ST_WR);
    reg_rd    = (state_q == ST_RD);
    tx_valid  = (state_q == ST_RESP);
    tx_data   = (state_q == ST_RESP) ? resp_q[7:0] : 8'd0;
    busy      = (state_q != ST_SYNC);
    reg_addr  = reg_addr_q;
    reg_wdata = reg_wdata_q;
    err_count = err_q;
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: write, read with tx stall, bad frames, resync, reset, timeout.
module tb_uart_cmd_parser;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_wr, reg_rd, reg_ack;
  logic [31:0] reg_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, busy;
  logic [7:0]  err_count;
  int          checks = 0;
  int          errors = 0;

  uart_cmd_parser #(.CLK_FREQ(1_000_000), .TIMEOUT_US(20), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_ack(reg_ack), .reg_rdata(reg_rdata), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] addr,
                            input logic [31:0] data, input logic [7:0] csum);
    send_byte(8'hA5);
    send_byte(cmd);
    send_byte(addr);
    send_byte(data[7:0]);
    send_byte(data[15:8]);
    send_byte(data[23:16]);
    send_byte(data[31:24]);
    send_byte(csum);
  endtask

  task automatic ack_cycle(input logic [31:0] rdata);
    reg_rdata = rdata;
    reg_ack   = 1'b1;
    tick();
    reg_ack   = 1'b0;
    reg_rdata = 32'd0;
  endtask

  // Waits (bounded) for a response byte, checks it and accepts it.
  task automatic expect_tx(input string tag, input logic [7:0] b);
    int n = 0;
    while (!tx_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, {39'd0, tx_valid}, 40'd1);
    chk(tag, {32'd0, tx_data}, {32'd0, b});
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx_data = 8'd0; rx_valid = 1'b0; reg_ack = 1'b0;
    reg_rdata = 32'd0; tx_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_wr", {39'd0, reg_wr}, 40'd0);
    chk("rst_rd", {39'd0, reg_rd}, 40'd0);
    chk("rst_txv", {39'd0, tx_valid}, 40'd0);
    chk("rst_busy", {39'd0, busy}, 40'd0);
    chk("rst_err", {32'd0, err_count}, 40'd0);
    chk("rst_addr", {32'd0, reg_addr}, 40'd0);

    // Write: checksum 01^10^78^56^34^12 = 19
    send_frame(8'h01, 8'h10, 32'h12345678, 8'h19);
    chk("wr_req", {39'd0, reg_wr}, 40'd1);
    chk("wr_addr", {32'd0, reg_addr}, 40'h10);
    chk("wr_data", {8'd0, reg_wdata}, 40'h12345678);
    send_byte(8'hA5);
    tick(); tick();
    chk("wr_hold", {39'd0, reg_wr}, 40'd1);
    chk("wr_notx", {39'd0, tx_valid}, 40'd0);
    ack_cycle(32'd0);
    chk("wr_drop", {39'd0, reg_wr}, 40'd0);
    chk("wr_txlat", {39'd0, tx_valid}, 40'd1);
    expect_tx("wr_ack", 8'h06);
    chk("wr_idle", {39'd0, busy}, 40'd0);
    chk("wr_err", {32'd0, err_count}, 40'd0);

    // Read with a 5-cycle stall in the middle of the response
    send_frame(8'h02, 8'h20, 32'h0, 8'h22);
    chk("rd_req", {39'd0, reg_rd}, 40'd1);
    chk("rd_nowr", {39'd0, reg_wr}, 40'd0);
    chk("rd_addr", {32'd0, reg_addr}, 40'h20);
    tick();
    ack_cycle(32'hDEADBEEF);
    chk("rd_drop", {39'd0, reg_rd}, 40'd0);
    expect_tx("rd_b0", 8'h06);
    expect_tx("rd_b1", 8'hEF);
    for (int i = 0; i < 5; i++) begin
      chk("rd_stall_v", {39'd0, tx_valid}, 40'd1);
      chk("rd_stall_d", {32'd0, tx_data}, 40'hBE);
      tick();
    end
    expect_tx("rd_b2", 8'hBE);
    expect_tx("rd_b3", 8'hAD);
    expect_tx("rd_b4", 8'hDE);
    chk("rd_idle", {39'd0, busy}, 40'd0);

    // Bad checksum, then bad command with a correct checksum (1F)
    send_frame(8'h01, 8'h10, 32'h12345678, 8'hFF);
    chk("bcs_nowr", {39'd0, reg_wr}, 40'd0);
    expect_tx("bcs_nak", 8'h15);
    chk("bcs_err", {32'd0, err_count}, 40'd1);
    send_frame(8'h07, 8'h10, 32'h12345678, 8'h1F);
    chk("bcmd_nowr", {39'd0, reg_wr | reg_rd}, 40'd0);
    expect_tx("bcmd_nak", 8'h15);
    chk("bcmd_err", {32'd0, err_count}, 40'd2);

    // Garbage before a valid frame is silently ignored
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    chk("gb_idle", {39'd0, busy}, 40'd0);
    send_frame(8'h01, 8'h33, 32'hCAFEF00D, 8'hFB);
    chk("gb_wr", {39'd0, reg_wr}, 40'd1);
    chk("gb_addr", {32'd0, reg_addr}, 40'h33);
    chk("gb_data", {8'd0, reg_wdata}, 40'hCAFEF00D);
    ack_cycle(32'd0);
    expect_tx("gb_ack", 8'h06);
    chk("gb_err", {32'd0, err_count}, 40'd2);

    // Reset during a read
    send_frame(8'h02, 8'h20, 32'h0, 8'h22);
    chk("rr_req", {39'd0, reg_rd}, 40'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr_rd", {39'd0, reg_rd}, 40'd0);
    chk("rr_txv", {39'd0, tx_valid}, 40'd0);
    chk("rr_err", {32'd0, err_count}, 40'd0);
    chk("rr_busy", {39'd0, busy}, 40'd0);
    send_frame(8'h01, 8'h10, 32'h12345678, 8'h19);
    chk("rr_wr", {39'd0, reg_wr}, 40'd1);
    ack_cycle(32'd0);
    expect_tx("rr_ack", 8'h06);

`ifdef UART_CMD_TIMEOUT_EN
    // Timeout after 20 idle cycles mid-frame: error, no response
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
    begin
      logic saw_tx = 1'b0;
      for (int i = 0; i < 30; i++) begin
        saw_tx = saw_tx | tx_valid;
        tick();
      end
      chk("to_notx", {39'd0, saw_tx}, 40'd0);
    end
    chk("to_idle", {39'd0, busy}, 40'd0);
    chk("to_err", {32'd0, err_count}, 40'd1);
    send_frame(8'h01, 8'h44, 32'h00000001, 8'h44);
    chk("to_wr", {39'd0, reg_wr}, 40'd1);
    chk("to_addr", {32'd0, reg_addr}, 40'h44);
    ack_cycle(32'd0);
    expect_tx("to_ack", 8'h06);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
